seq_lock_detector: RTL and testbench

- Downstream consumer of the periodic-sequence FSM's serial output.
- Samples one bit per qualified clock and detects the pattern 1011 (overlapping) with a Moore FSM.
- Counts matches and declares lock once matches recur at the expected spacing.
- The upstream generator emits 1,0,1,1,0,1,1,0,1,…, which matches every PERIOD=3 bits after the first.

---
 rtl/fsm_pkg.sv | 16 +
 rtl/sat_counter.sv | 24 ++
 rtl/seq_lock_detector.sv | 114 +++++++++++
 tb/tb_seq_lock_detector.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared encodings for the 1011 lock detector: FSM states, debug width
// and the pattern being hunted for.
package fsm_pkg;

  localparam int DBG_W = 3;
  localparam logic [3:0] PATTERN = 4'b1011;

  typedef enum logic [DBG_W-1:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; clear beats increment, reset loads INIT.
module sat_counter #(
  parameter int           W    = 8,
  parameter logic [W-1:0] MAX  = '1,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= INIT;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != MAX)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_lock_detector.sv
// Overlapping 1011 detector on a qualified serial stream, with a match
// counter and a lock flag that tracks whether matches arrive every PERIOD bits.
module seq_lock_detector
  import fsm_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int PERIOD = 3,
  parameter int LOCK_N = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             din,
  input  logic             count_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             locked,
  output logic [DBG_W-1:0] state_dbg
);

  localparam int IW = $clog2(PERIOD + 2);
  localparam int SW = $clog2(LOCK_N + 1);
  localparam logic [IW-1:0] INT_MAX    = IW'(PERIOD + 1);
  localparam logic [IW:0]   PERIOD_EXT = (IW + 1)'(PERIOD);
  localparam logic [SW-1:0] STREAK_MAX = SW'(LOCK_N);

  state_t        state;
  state_t        state_next;
  logic          hit;
  logic [IW-1:0] interval;
  logic [IW:0]   interval_inc;
  logic [SW-1:0] streak;
  logic [SW-1:0] streak_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
    end else begin
      state <= state_next;
    end
  end

  // Illegal encodings fall back to S0 even while the input is stalled.
  always_comb begin
    state_next = state;
    case (state)
      S0:      if (in_valid) state_next = din ? S1    : S0;
      S1:      if (in_valid) state_next = din ? S1    : S10;
      S10:     if (in_valid) state_next = din ? S101  : S0;
      S101:    if (in_valid) state_next = din ? S1011 : S10;
      S1011:   if (in_valid) state_next = din ? S1    : S10;
      default: state_next = S0;
    endcase
  end

  always_comb begin
    state_dbg = state;
    hit       = in_valid && (state == S101) && (din == PATTERN[0]);
  end

  sat_counter #(
    .W    (CNT_W)
  ) u_match_count (
    .clk  (clk),
    .reset(reset),
    .clr  (count_clr),
    .inc  (hit),
    .q    (match_count)
  );

  // Interval restarts at a match and saturates one past the expected spacing.
  sat_counter #(
    .W    (IW),
    .MAX  (INT_MAX),
    .INIT (INT_MAX)
  ) u_interval (
    .clk  (clk),
    .reset(reset),
    .clr  (hit),
    .inc  (in_valid && !hit),
    .q    (interval)
  );

  always_comb begin
    interval_inc = {1'b0, interval} + 1'b1;
    streak_next  = streak;
    if (hit) begin
      if (interval_inc == PERIOD_EXT) begin
        if (streak != STREAK_MAX) begin
          streak_next = streak + 1'b1;
        end
      end else begin
        streak_next = SW'(1);
      end
    end else if (in_valid && (interval_inc > PERIOD_EXT)) begin
      streak_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      match  <= 1'b0;
      streak <= '0;
      locked <= 1'b0;
    end else begin
      match  <= hit;
      streak <= streak_next;
      if (in_valid) begin
        locked <= (streak_next >= STREAK_MAX);
      end
    end
  end

endmodule

// File: tb/tb_seq_lock_detector.sv
// Directed bench for seq_lock_detector: a history-based reference model
// queues expected outputs per driven bit; they are popped after each edge.
module tb_seq_lock_detector;

  localparam int PERIOD = 3;
  localparam int LOCK_N = 2;
  localparam int MAX1   = 255;
  localparam int MAX2   = 3;

  typedef struct {
    int match;
    int count;
    int count2;
    int locked;
    int state;
    int streak;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       din = 1'b0;
  logic       count_clr = 1'b0;
  logic       match;
  logic [7:0] match_count;
  logic       locked;
  logic [2:0] state_dbg;
  logic       match2;
  logic [1:0] match_count2;
  logic       locked2;
  logic [2:0] state_dbg2;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  logic [3:0] m_hist;
  int m_cnt, m_cnt2, m_interval, m_streak, m_match, m_locked;

  seq_lock_detector dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .din        (din),
    .count_clr  (count_clr),
    .match      (match),
    .match_count(match_count),
    .locked     (locked),
    .state_dbg  (state_dbg)
  );

  seq_lock_detector #(.CNT_W(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .din        (din),
    .count_clr  (count_clr),
    .match      (match2),
    .match_count(match_count2),
    .locked     (locked2),
    .state_dbg  (state_dbg2)
  );

  always #5 clk = ~clk;

  function automatic int stateOf(input logic [3:0] h);
    if (h == 4'b1011)          return 4;
    else if (h[2:0] == 3'b101) return 3;
    else if (h[1:0] == 2'b10)  return 2;
    else if (h[0])             return 1;
    else                       return 0;
  endfunction

  task automatic applyStimulus(input logic r, input logic v, input logic d, input logic c);
    exp_t e;
    logic hit;
    reset     = r;
    in_valid  = v;
    din       = d;
    count_clr = c;
    if (r) begin
      m_hist = 4'b0000; m_cnt = 0; m_cnt2 = 0;
      m_interval = PERIOD + 1; m_streak = 0; m_match = 0; m_locked = 0;
    end else begin
      hit = v && ({m_hist[2:0], d} == 4'b1011);
      if (v) m_hist = {m_hist[2:0], d};
      m_match = hit ? 1 : 0;
      if (c) begin
        m_cnt = 0; m_cnt2 = 0;
      end else if (hit) begin
        if (m_cnt < MAX1) m_cnt++;
        if (m_cnt2 < MAX2) m_cnt2++;
      end
      if (hit) begin
        if (m_interval + 1 == PERIOD) m_streak = (m_streak < LOCK_N) ? m_streak + 1 : LOCK_N;
        else m_streak = 1;
        m_interval = 0;
      end else if (v) begin
        if (m_interval + 1 > PERIOD) m_streak = 0;
        if (m_interval < PERIOD + 1) m_interval++;
      end
      if (v) m_locked = (m_streak >= LOCK_N) ? 1 : 0;
    end
    e.match = m_match; e.count = m_cnt; e.count2 = m_cnt2;
    e.locked = m_locked; e.state = stateOf(m_hist); e.streak = m_streak;
    exp_q.push_back(e);
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s observed empty-queue expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      checkVal({tag, ".match"},  32'(match),        32'(e.match));
      checkVal({tag, ".count"},  32'(match_count),  32'(e.count));
      checkVal({tag, ".locked"}, 32'(locked),       32'(e.locked));
      checkVal({tag, ".state"},  32'(state_dbg),    32'(e.state));
      checkVal({tag, ".streak"}, 32'(dut.streak),   32'(e.streak));
      checkVal({tag, ".match2"}, 32'(match2),       32'(e.match));
      checkVal({tag, ".count2"}, 32'(match_count2), 32'(e.count2));
      checkVal({tag, ".locked2"},32'(locked2),      32'(e.locked));
      checkVal({tag, ".state2"}, 32'(state_dbg2),   32'(e.state));
    end
  endtask

  task automatic step(input logic r, input logic v, input logic d, input logic c, input string tag);
    applyStimulus(r, v, d, c);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic feed(input logic [31:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, 1'b1, bits[i], 1'b0, tag);
    end
  endtask

  initial begin
    // Scenario 1: locking onto the periodic stream
    step(1'b1, 1'b0, 1'b0, 1'b0, "s1_reset");
    feed(32'b1011011011, 10, "s1_stream");

    // Scenario 2: a missing match breaks lock one bit past its slot
    feed(32'b0100, 4, "s2_miss");
    feed(32'b11011, 5, "s2_recover");

    // Scenario 3: stall mid-pattern
    step(1'b1, 1'b0, 1'b0, 1'b0, "s3_reset");
    feed(32'b10110, 5, "s3_pre");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, i[0], 1'b0, "s3_stall");
    end
    feed(32'b11011, 5, "s3_post");

    // Scenario 4: clear coinciding with a hit
    step(1'b1, 1'b0, 1'b0, 1'b0, "s4_reset");
    feed(32'b101101, 6, "s4_pre");
    step(1'b0, 1'b1, 1'b1, 1'b1, "s4_clr_hit");
    feed(32'b011, 3, "s4_post");
    step(1'b0, 1'b1, 1'b0, 1'b1, "s4_clr_only");

    // Scenario 5: saturation (narrow instance pins at 3)
    step(1'b1, 1'b0, 1'b0, 1'b0, "s5_reset");
    feed(32'b1011011011011011, 16, "s5_sat");

    // Scenario 6: reset while in S101 discards the partial match
    step(1'b1, 1'b0, 1'b0, 1'b0, "s6_reset");
    feed(32'b101, 3, "s6_pre");
    step(1'b1, 1'b1, 1'b1, 1'b0, "s6_mid_reset");
    step(1'b0, 1'b1, 1'b1, 1'b0, "s6_first");
    feed(32'b011, 3, "s6_match");
    feed(32'b00, 2, "s6_tail");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
